// File: rtl/reg_file_param.sv
// Parameterised register file: two registered read ports, one write port and a
// one-register-per-cycle clear sweep that runs while busy is high.
module reg_file_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic [ADDR_W-1:0] dest,
  input  logic [DATA_W-1:0] writeVal,
  input  logic              writeEn,
  input  logic              readEn,
  input  logic              clrReq,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic              rdValid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] reg1_q, reg1_d;
  logic [DATA_W-1:0] reg2_q, reg2_d;
  logic              rd_valid_q, rd_valid_d;

  logic              busy_s;
  logic              user_wr_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  // Busy is decoded straight from the state register.
  always_comb begin
    busy_s = (state_q == ST_CLEAR);
  end

  // Clear-sweep FSM: the counter wraps to zero on exit so it never leaves range.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_IDLE: begin
        sweep_d = '0;
        if (clrReq) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (sweep_q == LAST_IDX) begin
          state_d = ST_IDLE;
          sweep_d = '0;
        end else begin
          state_d = ST_CLEAR;
          sweep_d = sweep_q + ADDR_W'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        sweep_d = '0;
      end
    endcase
  end

  // Single write port: the sweep owns it while busy, so user writes are dropped.
  always_comb begin
    user_wr_s = writeEn && !busy_s;
    if (busy_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = sweep_q;
      wr_data_s = '0;
    end else if (writeEn) begin
      wr_en_s   = 1'b1;
      wr_addr_s = dest;
      wr_data_s = writeVal;
    end else begin
      wr_en_s   = 1'b0;
      wr_addr_s = dest;
      wr_data_s = writeVal;
    end
  end

  // Read ports with write-first bypass, evaluated independently per port.
  always_comb begin
    reg1_d     = reg1_q;
    reg2_d     = reg2_q;
    rd_valid_d = readEn;
    if (readEn) begin
      if (user_wr_s && (src1 == dest)) begin
        reg1_d = writeVal;
      end else begin
        reg1_d = mem_q[src1];
      end
      if (user_wr_s && (src2 == dest)) begin
        reg2_d = writeVal;
      end else begin
        reg2_d = mem_q[src2];
      end
    end else begin
      reg1_d = reg1_q;
      reg2_d = reg2_q;
    end
  end

  // State, storage and output registers; reset wins over every request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sweep_q    <= '0;
      reg1_q     <= '0;
      reg2_q     <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
      rd_valid_q <= rd_valid_d;
      if (wr_en_s) begin
        mem_q[wr_addr_s] <= wr_data_s;
      end
    end
  end

  assign reg1    = reg1_q;
  assign reg2    = reg2_q;
  assign rdValid = rd_valid_q;
  assign busy    = busy_s;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: a 16x16 and an 8x32 instance are exercised
// in turn against an array-based reference model of the register file.
module tb_reg_file_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  src1, src2, dest;
  logic [31:0] wval;
  logic        we, re, clr;
  int          sel;

  logic        we_a, re_a, clr_a, we_b, re_b, clr_b;
  logic [15:0] a_r1, a_r2;
  logic        a_v, a_b;
  logic [31:0] b_r1, b_r2;
  logic        b_v, b_b;

  assign we_a  = we  && (sel == 0);
  assign re_a  = re  && (sel == 0);
  assign clr_a = clr && (sel == 0);
  assign we_b  = we  && (sel == 1);
  assign re_b  = re  && (sel == 1);
  assign clr_b = clr && (sel == 1);

  reg_file_param #(.DATA_W(16), .ADDR_W(4)) dut_a (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .dest(dest),
    .writeVal(wval[15:0]), .writeEn(we_a), .readEn(re_a), .clrReq(clr_a),
    .reg1(a_r1), .reg2(a_r2), .rdValid(a_v), .busy(a_b)
  );

  reg_file_param #(.DATA_W(32), .ADDR_W(3)) dut_b (
    .clk(clk), .rst(rst), .src1(src1[2:0]), .src2(src2[2:0]), .dest(dest[2:0]),
    .writeVal(wval), .writeEn(we_b), .readEn(re_b), .clrReq(clr_b),
    .reg1(b_r1), .reg2(b_r2), .rdValid(b_v), .busy(b_b)
  );

  logic [31:0] m_r1, m_r2;
  logic        m_v, m_b;
  always_comb begin
    m_r1 = (sel == 0) ? {16'h0000, a_r1} : b_r1;
    m_r2 = (sel == 0) ? {16'h0000, a_r2} : b_r2;
    m_v  = (sel == 0) ? a_v : b_v;
    m_b  = (sel == 0) ? a_b : b_b;
  end

  // Reference model: plain array plus "clear in progress / next index to zero".
  logic [31:0] mem_m [16];
  int          depth;
  logic [31:0] mask;
  bit          busy_m;
  int          sweep_m;
  logic [31:0] out1_m, out2_m;

  typedef struct packed {
    int          cyc;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int  total = 0;
  int  bad = 0;
  bit  mon_en = 1'b0;

  task automatic tick();
    int          a1, a2, ad;
    logic [31:0] v, d1, d2;
    bit          wr_ok;
    exp_t        e;
    a1 = int'(src1) % depth;
    a2 = int'(src2) % depth;
    ad = int'(dest) % depth;
    v  = wval & mask;
    d1 = 32'h0;
    d2 = 32'h0;
    wr_ok = we && !busy_m;
    if (rst && re) begin
      d1 = (wr_ok && a1 == ad) ? v : mem_m[a1];
      d2 = (wr_ok && a2 == ad) ? v : mem_m[a2];
      e.cyc = edges + 1;
      e.d1  = d1;
      e.d2  = d2;
      q.push_back(e);
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
      busy_m  = 1'b0;
      sweep_m = 0;
      out1_m  = 32'h0;
      out2_m  = 32'h0;
    end else begin
      if (re) begin
        out1_m = d1;
        out2_m = d2;
      end
      if (busy_m) begin
        mem_m[sweep_m] = 32'h0;
        if (sweep_m == depth - 1) begin
          busy_m  = 1'b0;
          sweep_m = 0;
        end else begin
          sweep_m = sweep_m + 1;
        end
      end else begin
        if (we) mem_m[ad] = v;
        if (clr) begin
          busy_m  = 1'b1;
          sweep_m = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    we  = 1'b0;
    re  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [31:0] v);
    we = 1'b1; dest = 4'(a); wval = v;
    tick();
    idle();
  endtask

  task automatic do_read(input int a1, input int a2);
    re = 1'b1; src1 = 4'(a1); src2 = 4'(a2);
    tick();
    idle();
  endtask

  task automatic random_phase(input int n);
    repeat (n) begin
      rst  = ($urandom_range(0, 149) != 0);
      re   = $urandom_range(0, 1) != 0;
      we   = $urandom_range(0, 1) != 0;
      clr  = ($urandom_range(0, 29) == 0);
      src1 = 4'($urandom);
      src2 = ($urandom_range(0, 3) == 0) ? src1 : 4'($urandom);
      dest = ($urandom_range(0, 2) == 0) ? src1 : 4'($urandom);
      wval = $urandom;
      tick();
    end
    rst = 1'b1;
    idle();
    tick();
    tick();
  endtask

  task automatic start_dut(input int s);
    mon_en = 1'b0;
    sel    = s;
    depth  = (s == 0) ? 16 : 8;
    mask   = (s == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    q.delete();
    rst = 1'b0;
    idle();
    tick();
    tick();
    rst    = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: checks busy every cycle, pops one expectation per rdValid, else checks hold.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (m_b !== busy_m) begin
        bad++;
        $display("FAIL busy: got %0b want %0b at edge %0d", m_b, busy_m, edges);
      end
      if (m_v === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rdvalid_unexpected: got rdValid=1 want 0 at edge %0d", edges);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.cyc != edges) begin
            bad++;
            $display("FAIL read_latency: got edge %0d want edge %0d", edges, mon_e.cyc);
          end
          total++;
          if (m_r1 !== mon_e.d1) begin
            bad++;
            $display("FAIL reg1: got %h want %h at edge %0d", m_r1, mon_e.d1, edges);
          end
          total++;
          if (m_r2 !== mon_e.d2) begin
            bad++;
            $display("FAIL reg2: got %h want %h at edge %0d", m_r2, mon_e.d2, edges);
          end
        end
      end else begin
        total++;
        if (q.size() > 0 && q[0].cyc <= edges) begin
          bad++;
          $display("FAIL rdvalid_missing: got rdValid=%b want 1 at edge %0d", m_v, edges);
          void'(q.pop_front());
        end
        total++;
        if (m_r1 !== out1_m || m_r2 !== out2_m) begin
          bad++;
          $display("FAIL hold: got %h/%h want %h/%h at edge %0d",
                   m_r1, m_r2, out1_m, out2_m, edges);
        end
      end
    end
  end

  initial begin
    src1 = 4'h0; src2 = 4'h0; dest = 4'h0; wval = 32'h0;
    busy_m = 1'b0; sweep_m = 0; out1_m = 32'h0; out2_m = 32'h0;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;

    // 16-bit x 16 instance
    start_dut(0);
    do_write(0, 32'h0000_00E7);
    do_read(0, 1);
    we = 1'b1; dest = 4'd5; wval = 32'h0000_BEEF;
    re = 1'b1; src1 = 4'd5; src2 = 4'd5;
    tick();
    idle();
    for (int i = 0; i < 16; i++) do_write(i, 32'h1000 + 32'(i));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (3) tick();
    re = 1'b1; src1 = 4'd2; src2 = 4'd9;
    we = 1'b1; dest = 4'd9; wval = 32'h0000_AAAA;
    tick();
    idle();
    repeat (12) begin
      we = 1'b1; dest = 4'($urandom); wval = $urandom;
      tick();
    end
    idle();
    tick();
    for (int i = 0; i < 16; i++) do_read(i, 15 - i);

    we = 1'b1; dest = 4'd3; wval = 32'h0000_1234; clr = 1'b1;
    tick();
    idle();
    do_read(3, 3);
    repeat (16) tick();
    do_read(3, 4);

    for (int i = 0; i < 16; i++) do_write(i, 32'h2000 + 32'(i));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    rst = 1'b0; re = 1'b1; we = 1'b1; clr = 1'b1; src1 = 4'd9; src2 = 4'd10;
    tick();
    rst = 1'b1;
    idle();
    tick();
    for (int i = 0; i < 16; i++) do_read(i, i);
    random_phase(500);

    // 32-bit x 8 instance
    start_dut(1);
    do_write(7, 32'hDEAD_BEEF);
    do_read(7, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (9) tick();
    for (int i = 0; i < 8; i++) do_read(i, 7 - i);
    random_phase(400);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending reads want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, meaning register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 4, meaning address width; depth DEPTH = 2**ADDR_W registers.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port src1  input  ADDR_W  read port 1 address.
REQ-006 SHALL provide port src2  input  ADDR_W  read port 2 address.
REQ-007 SHALL provide port dest  input  ADDR_W  write address.
REQ-008 SHALL provide port writeVal  input  DATA_W  write data.
REQ-009 SHALL provide port writeEn  input  1  write request.
REQ-010 SHALL provide port readEn  input  1  read request, both ports.
REQ-011 SHALL provide port clrReq  input  1  start sequential clear of all registers.
REQ-012 SHALL provide port reg1  output  DATA_W  registered read data, port 1.
REQ-013 SHALL provide port reg2  output  DATA_W  registered read data, port 2.
REQ-014 SHALL provide port rdValid  output  1  reg1/reg2 updated by a read this cycle.
REQ-015 SHALL provide port busy  output  1  clear sweep in progress.

Function
REQ-016 SHALL store DEPTH registers of DATA_W bits; no register is hardwired.
REQ-017 SHALL, when writeEn=1 and busy=0 at a rising edge, load writeVal into register dest.
REQ-018 SHALL, when readEn=1 at a rising edge, load reg1/reg2 from src1/src2 and set rdValid=1 the following cycle; latency exactly 1 cycle.
REQ-019 SHALL hold reg1/reg2 unchanged and drive rdValid=0 in cycles following readEn=0.
REQ-020 SHALL bypass: same-edge readEn=1, writeEn=1, busy=0, srcN==dest -> regN receives writeVal (write-first), independently per port.
REQ-021 SHALL allow src1==src2; both outputs receive identical data.
REQ-022 SHALL implement FSM IDLE/CLEAR; IDLE -> CLEAR on clrReq=1; busy=1 exactly while in CLEAR.
REQ-023 SHALL, in CLEAR, zero one register per cycle via sweep counter 0..DEPTH-1, returning to IDLE after zeroing DEPTH-1; sweep takes exactly DEPTH cycles.
REQ-024 SHALL ignore writeEn while busy=1 (write dropped, no retry).
REQ-025 SHALL service reads during CLEAR: already-swept registers read 0; the register being zeroed this edge reads its pre-clear value; others read stored value.
REQ-026 SHALL ignore clrReq while busy=1 (no restart); clrReq and writeEn on the same IDLE edge -> write performed, then clear starts next cycle and zeroes it.
REQ-027 SHALL wrap sweep counter to 0 on CLEAR exit; no out-of-range access for any ADDR_W.

Reset
REQ-028 SHALL, on rising edge with rst=0, zero all registers, reg1, reg2, rdValid, busy, sweep counter, and enter IDLE in the same edge.
REQ-029 SHALL give rst priority over writeEn, readEn, clrReq, including mid-sweep (sweep aborted, all registers zero).

Verification
REQ-030 SHALL verify write/read: write 16'h00E7 to r0, next cycle readEn, src1=0, src2=1 -> reg1=16'h00E7, reg2=0, rdValid=1 one cycle after readEn.
REQ-031 SHALL verify bypass: same edge writeEn, dest=5, writeVal=16'hBEEF, readEn, src1=5, src2=5 -> reg1=reg2=16'hBEEF next cycle.
REQ-032 SHALL verify clear: fill r0..r15 with 16'h1000+i, pulse clrReq -> busy=1 for 16 cycles; writeEn during sweep dropped; afterward all reads return 0.
REQ-033 SHALL verify read during sweep: at sweep index 3 read src1=2, src2=9 -> reg1=0, reg2=16'h1009.
REQ-034 SHALL verify reset mid-sweep: rst=0 at sweep index 7 -> busy=0, rdValid=0, reg1=reg2=0 next cycle, all registers 0.
REQ-035 SHALL verify parameterisation: DATA_W=32, ADDR_W=3 -> write 32'hDEADBEEF to r7 reads back; clear sweep takes 8 cycles.
